// File: rtl/if_id_queue.sv
// Fetch-to-decode instruction queue: circular FIFO of {PC, instr, misalign}.
// Presents a NOP bubble when empty; FLUSH drops all in-flight entries.
module if_id_queue #(
  parameter int          DEPTH = 2,
  parameter logic [31:0] NOP   = 32'h0000_0013
) (
  input  logic                       CLK,
  input  logic                       RSTn,
  input  logic                       FLUSH,
  input  logic                       IN_VALID,
  output logic                       IN_READY,
  input  logic [31:0]                IN_PC,
  input  logic [31:0]                IN_INSTR,
  output logic                       OUT_VALID,
  input  logic                       OUT_READY,
  output logic [31:0]                OUT_PC,
  output logic [31:0]                OUT_INSTR,
  output logic                       OUT_MISALIGN,
  output logic [$clog2(DEPTH):0]     COUNT
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        mis;
  } entry_t;

  entry_t          mem [DEPTH];
  logic [AW-1:0]   rptr;
  logic [AW-1:0]   wptr;
  logic [CW-1:0]   cnt;
  logic            push;
  logic            pop;
  entry_t          head;
  entry_t          wr_entry;

  assign IN_READY  = (cnt < CW'(DEPTH));
  assign OUT_VALID = (cnt != '0);
  assign COUNT     = cnt;

  assign push = IN_VALID & IN_READY;
  assign pop  = OUT_VALID & OUT_READY;

  assign wr_entry.pc    = IN_PC;
  assign wr_entry.instr = IN_INSTR;
  assign wr_entry.mis   = (IN_PC[1:0] != 2'b00);

  assign head = mem[rptr];

  always_comb begin
    OUT_PC       = 32'h0;
    OUT_INSTR    = NOP;
    OUT_MISALIGN = 1'b0;
    if (OUT_VALID) begin
      OUT_PC       = head.pc;
      OUT_INSTR    = head.instr;
      OUT_MISALIGN = head.mis;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge CLK) begin
    if (!RSTn || FLUSH) begin
      rptr <= '0;
      wptr <= '0;
      cnt  <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      unique case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RSTn && !FLUSH && push)
      mem[wptr] <= wr_entry;
  end

endmodule

// File: tb/tb_if_id_queue.sv
// Directed self-checking bench for if_id_queue (DEPTH=2).
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_if_id_queue;

  logic        CLK;
  logic        RSTn;
  logic        FLUSH;
  logic        IN_VALID;
  logic        IN_READY;
  logic [31:0] IN_PC;
  logic [31:0] IN_INSTR;
  logic        OUT_VALID;
  logic        OUT_READY;
  logic [31:0] OUT_PC;
  logic [31:0] OUT_INSTR;
  logic        OUT_MISALIGN;
  logic [1:0]  COUNT;

  int total = 0;
  int bad   = 0;

  if_id_queue #(.DEPTH(2), .NOP(32'h0000_0013)) dut (
    .CLK(CLK), .RSTn(RSTn), .FLUSH(FLUSH),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .IN_PC(IN_PC), .IN_INSTR(IN_INSTR),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .OUT_PC(OUT_PC), .OUT_INSTR(OUT_INSTR),
    .OUT_MISALIGN(OUT_MISALIGN), .COUNT(COUNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RSTn = 0; FLUSH = 0; IN_VALID = 0;
    IN_PC = 0; IN_INSTR = 0; OUT_READY = 0;
    step(); step();
    RSTn = 1;
    total++;
    if (COUNT !== 2'd0) begin
      bad++; $display("FAIL rst_count got=%0d exp=0", COUNT);
    end
    total++;
    if (OUT_VALID !== 1'b0 || IN_READY !== 1'b1) begin
      bad++;
      $display("FAIL rst_hs got v=%b r=%b exp v=0 r=1",
               OUT_VALID, IN_READY);
    end
    total++;
    if (OUT_INSTR !== 32'h13 || OUT_PC !== 32'h0 ||
        OUT_MISALIGN !== 1'b0) begin
      bad++;
      $display("FAIL rst_out got pc=%h in=%h m=%b exp 0/13/0",
               OUT_PC, OUT_INSTR, OUT_MISALIGN);
    end
  endtask

  task automatic test_fill();
    OUT_READY = 0;
    IN_VALID = 1; IN_PC = 32'h0; IN_INSTR = 32'hA;
    step();
    total++;
    if (COUNT !== 2'd1 || OUT_VALID !== 1'b1 || IN_READY !== 1'b1) begin
      bad++;
      $display("FAIL fill1 got c=%0d v=%b r=%b exp 1/1/1",
               COUNT, OUT_VALID, IN_READY);
    end
    IN_PC = 32'h4; IN_INSTR = 32'hB;
    step();
    total++;
    if (COUNT !== 2'd2 || IN_READY !== 1'b0) begin
      bad++;
      $display("FAIL fill_full got c=%0d r=%b exp 2/0", COUNT, IN_READY);
    end
    IN_PC = 32'h8; IN_INSTR = 32'hC;
    step();
    total++;
    if (COUNT !== 2'd2 || OUT_PC !== 32'h0 || OUT_INSTR !== 32'hA) begin
      bad++;
      $display("FAIL fill_hold got c=%0d pc=%h in=%h exp 2/0/a",
               COUNT, OUT_PC, OUT_INSTR);
    end
    OUT_READY = 1;
    step();
    total++;
    if (COUNT !== 2'd1 || OUT_PC !== 32'h4 || OUT_INSTR !== 32'hB) begin
      bad++;
      $display("FAIL fill_pop1 got c=%0d pc=%h in=%h exp 1/4/b",
               COUNT, OUT_PC, OUT_INSTR);
    end
    step();
    total++;
    if (COUNT !== 2'd1 || OUT_PC !== 32'h8 || OUT_INSTR !== 32'hC) begin
      bad++;
      $display("FAIL fill_pop2 got c=%0d pc=%h in=%h exp 1/8/c",
               COUNT, OUT_PC, OUT_INSTR);
    end
    IN_VALID = 0;
    step();
    total++;
    if (COUNT !== 2'd0 || OUT_INSTR !== 32'h13 || OUT_VALID !== 1'b0) begin
      bad++;
      $display("FAIL fill_drain got c=%0d in=%h v=%b exp 0/13/0",
               COUNT, OUT_INSTR, OUT_VALID);
    end
  endtask

  task automatic test_stream();
    logic [31:0] pc;
    OUT_READY = 1;
    IN_VALID = 1;
    for (int k = 0; k < 10; k++) begin
      pc = 32'h100 + 32'(4 * k);
      IN_PC = pc; IN_INSTR = 32'h1000 + 32'(k);
      step();
      total++;
      if (COUNT !== 2'd1 || OUT_PC !== pc ||
          OUT_INSTR !== 32'h1000 + 32'(k)) begin
        bad++;
        $display("FAIL stream%0d got c=%0d pc=%h in=%h exp 1/%h/%h",
                 k, COUNT, OUT_PC, OUT_INSTR, pc, 32'h1000 + 32'(k));
      end
    end
    IN_VALID = 0;
    step();
    total++;
    if (COUNT !== 2'd0) begin
      bad++; $display("FAIL stream_end got c=%0d exp 0", COUNT);
    end
  endtask

  task automatic test_flush();
    OUT_READY = 0;
    IN_VALID = 1; IN_PC = 32'h300; IN_INSTR = 32'h3;
    step();
    IN_PC = 32'h304;
    step();
    FLUSH = 1; IN_PC = 32'h200; IN_INSTR = 32'h2;
    step();
    total++;
    if (COUNT !== 2'd0 || OUT_VALID !== 1'b0 || IN_READY !== 1'b1) begin
      bad++;
      $display("FAIL flush_full got c=%0d v=%b r=%b exp 0/0/1",
               COUNT, OUT_VALID, IN_READY);
    end
    FLUSH = 0; IN_PC = 32'h400; IN_INSTR = 32'h4;
    step();
    FLUSH = 1; IN_PC = 32'h404;
    step();
    total++;
    if (COUNT !== 2'd0 || OUT_VALID !== 1'b0) begin
      bad++;
      $display("FAIL flush_push got c=%0d v=%b exp 0/0",
               COUNT, OUT_VALID);
    end
    FLUSH = 0; IN_PC = 32'h500; IN_INSTR = 32'h5;
    step();
    IN_VALID = 0;
    total++;
    if (COUNT !== 2'd1 || OUT_PC !== 32'h500 || OUT_INSTR !== 32'h5) begin
      bad++;
      $display("FAIL flush_after got c=%0d pc=%h in=%h exp 1/500/5",
               COUNT, OUT_PC, OUT_INSTR);
    end
    OUT_READY = 1;
    step();
    total++;
    if (COUNT !== 2'd0) begin
      bad++; $display("FAIL flush_drain got c=%0d exp 0", COUNT);
    end
  endtask

  task automatic test_misalign();
    OUT_READY = 0;
    IN_VALID = 1; IN_PC = 32'h102; IN_INSTR = 32'h77;
    step();
    total++;
    if (OUT_MISALIGN !== 1'b1 || OUT_PC !== 32'h102) begin
      bad++;
      $display("FAIL mis_set got m=%b pc=%h exp 1/102",
               OUT_MISALIGN, OUT_PC);
    end
    IN_PC = 32'h104; IN_INSTR = 32'h78;
    step();
    IN_VALID = 0; OUT_READY = 1;
    step();
    total++;
    if (OUT_MISALIGN !== 1'b0 || OUT_PC !== 32'h104 ||
        COUNT !== 2'd1) begin
      bad++;
      $display("FAIL mis_clr got m=%b pc=%h c=%0d exp 0/104/1",
               OUT_MISALIGN, OUT_PC, COUNT);
    end
    step();
  endtask

  task automatic test_reset_mid();
    OUT_READY = 0;
    IN_VALID = 1; IN_PC = 32'h600; IN_INSTR = 32'h6;
    step();
    IN_PC = 32'h601;
    step();
    total++;
    if (COUNT !== 2'd2) begin
      bad++; $display("FAIL rmid_pre got c=%0d exp 2", COUNT);
    end
    RSTn = 0; IN_PC = 32'h608;
    step();
    RSTn = 1; IN_VALID = 0; OUT_READY = 1;
    total++;
    if (COUNT !== 2'd0 || OUT_VALID !== 1'b0 || IN_READY !== 1'b1 ||
        OUT_PC !== 32'h0 || OUT_INSTR !== 32'h13 ||
        OUT_MISALIGN !== 1'b0) begin
      bad++;
      $display("FAIL rmid got c=%0d v=%b r=%b pc=%h in=%h m=%b",
               COUNT, OUT_VALID, IN_READY, OUT_PC, OUT_INSTR,
               OUT_MISALIGN);
    end
    step();
    total++;
    if (COUNT !== 2'd0 || OUT_VALID !== 1'b0) begin
      bad++;
      $display("FAIL rmid_post got c=%0d v=%b exp 0/0",
               COUNT, OUT_VALID);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_stream();
    test_flush();
    test_misalign();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
